// File: rtl/bd_encoder.sv
// BD input-word encoder: prepends each leaf's programmable route code to the
// payload and splits wide payloads into up to three BD words, LSB chunk first.
module bd_encoder #(
    parameter int NLEAF  = 5,
    parameter int NPAY   = 27,
    parameter int NBD    = 21,
    parameter int NROUTE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_v,
    output logic              in_a,
    input  logic [NLEAF-1:0]  in_leaf_code,
    input  logic [NPAY-1:0]   in_payload,
    output logic              out_v,
    input  logic              out_a,
    output logic [NBD-1:0]    out_d,
    input  logic              cfg_we,
    input  logic [NLEAF-1:0]  cfg_leaf,
    input  logic [NROUTE-1:0] cfg_route,
    input  logic [3:0]        cfg_route_len,
    input  logic [1:0]        cfg_nchunks,
    output logic              err_drop
);

    localparam int NENT = 1 << NLEAF;
    localparam int EXTW = 3 * NBD;

    typedef enum logic {IDLE, BUSY} state_t;

    // Chunk k: route[L-1:0] in the top L bits, payload[k*D +: D] below, D = NBD-L.
    function automatic logic [NBD-1:0] encode(
        input logic [NROUTE-1:0] route,
        input logic [3:0]        len,
        input logic [NPAY-1:0]   pay,
        input logic [1:0]        k
    );
        logic [7:0]        d;
        logic [7:0]        off;
        logic [EXTW-1:0]   ext;
        logic [NBD-1:0]    dmask;
        logic [NBD-1:0]    rfield;
        logic [NROUTE-1:0] rmask;
        d      = 8'(NBD) - 8'(len);
        off    = 8'(k) * d;
        ext    = EXTW'(pay) >> off;
        dmask  = {NBD{1'b1}} >> len;
        rmask  = {NROUTE{1'b1}} >> (4'(NROUTE) - len);
        rfield = NBD'(route & rmask) << d;
        return rfield | (ext[NBD-1:0] & dmask);
    endfunction

    logic [NROUTE-1:0] tbl_route_q [NENT];
    logic [3:0]        tbl_len_q   [NENT];
    logic [1:0]        tbl_nch_q   [NENT];
    logic [3:0]        cfg_len_clamped;

    assign cfg_len_clamped = (cfg_route_len > 4'(NROUTE)) ? 4'(NROUTE) : cfg_route_len;

    // NOTE: the route table sits in the async reset domain on purpose: every
    // entry must come back as pass-through, so it cannot be plain RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NENT; i++) begin
                tbl_route_q[i] <= '0;
                tbl_len_q[i]   <= '0;
                tbl_nch_q[i]   <= 2'd1;
            end
        end else if (cfg_we) begin
            tbl_route_q[cfg_leaf] <= cfg_route;
            tbl_len_q[cfg_leaf]   <= cfg_len_clamped;
            tbl_nch_q[cfg_leaf]   <= cfg_nchunks;
        end
    end

    logic [NROUTE-1:0] rd_route;
    logic [3:0]        rd_len;
    logic [1:0]        rd_nch;

    // Table reads see pre-edge contents, so a same-edge cfg write is not used.
    assign rd_route = tbl_route_q[in_leaf_code];
    assign rd_len   = tbl_len_q[in_leaf_code];
    assign rd_nch   = tbl_nch_q[in_leaf_code];

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [NPAY-1:0]   pay_q, pay_d;
    logic [NROUTE-1:0] wroute_q, wroute_d;
    logic [3:0]        wlen_q, wlen_d;
    logic [1:0]        wnch_q, wnch_d;
    logic              out_v_q, out_v_d;
    logic [NBD-1:0]    out_d_q, out_d_d;
    logic              err_q, err_d;
    logic              accept;

    assign in_a     = (state_q == IDLE) && (!out_v_q || out_a);
    assign accept   = in_v && in_a;
    assign out_v    = out_v_q;
    assign out_d    = out_d_q;
    assign err_drop = err_q;

    // NOTE: every next-state signal gets its hold value first so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        pay_d    = pay_q;
        wroute_d = wroute_q;
        wlen_d   = wlen_q;
        wnch_d   = wnch_q;
        out_v_d  = out_v_q;
        out_d_d  = out_d_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (out_v_q && out_a) out_v_d = 1'b0;
                if (accept) begin
                    if (rd_nch == 2'd0) begin
                        err_d = 1'b1;
                    end else begin
                        out_v_d = 1'b1;
                        out_d_d = encode(rd_route, rd_len, in_payload, 2'd0);
                        if (rd_nch > 2'd1) begin
                            pay_d    = in_payload;
                            wroute_d = rd_route;
                            wlen_d   = rd_len;
                            wnch_d   = rd_nch;
                            k_d      = 2'd1;
                            state_d  = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                if (out_a) begin
                    out_d_d = encode(wroute_q, wlen_q, pay_q, k_q);
                    k_d     = k_q + 2'd1;
                    if (k_q == wnch_q - 2'd1) begin
                        k_d     = 2'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            pay_q    <= '0;
            wroute_q <= '0;
            wlen_q   <= '0;
            wnch_q   <= '0;
            out_v_q  <= 1'b0;
            out_d_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            pay_q    <= pay_d;
            wroute_q <= wroute_d;
            wlen_q   <= wlen_d;
            wnch_q   <= wnch_d;
            out_v_q  <= out_v_d;
            out_d_q  <= out_d_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/bd_encoder.md
Name: bd_encoder

Overview:
- Host-to-chip counterpart of the BD output decoder.
- Accepts decoded words (leaf_code + payload) from the host-side router and produces 21-bit BD input words.
- Each leaf's programmable route code is prepended to the payload. Payloads wider than one word are split into up to 3 chunks.
- Sits between the PC-side router and the BD serializer/handshaker.

Parameters:
NLEAF, 5, leaf_code width (32 leaves)
NPAY, 27, input payload width
NBD, 21, BD word width
NROUTE, 8, max route code length in bits

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_v  in  1  input valid
in_a  out  1  input accept
in_leaf_code  in  NLEAF  destination leaf
in_payload  in  NPAY  payload
out_v  out  1  BD word valid
out_a  in  1  BD word accept
out_d  out  NBD  encoded BD word
cfg_we  in  1  route-table write strobe
cfg_leaf  in  NLEAF  table entry written
cfg_route  in  NROUTE  route code, right-aligned
cfg_route_len  in  4  route code length, 0..8; values >8 are clamped to 8
cfg_nchunks  in  2  chunks per word: 0 = drop, 1..3
err_drop  out  1  one-cycle pulse when a word to a drop leaf is consumed

Behaviour:
- Handshake
  - A transfer occurs on a rising clk edge where v and a are both high.
  - out_v/out_d are registered. Once out_v is high, out_d holds stable until transfer.
- Reset
  - Reset is asynchronous and active-high; nothing survives it.
  - out_v=0, out_d=0, err_drop=0, FSM=IDLE, chunk counter=0.
  - Every table entry resets to route_len=0, route=0, nchunks=1 (pass-through).
- Route table
  - 32 entries, written on any edge with cfg_we=1.
  - The entry is snapshotted into working registers on input accept. A write to the same leaf on the accept edge is not visible to that word; the old value is used.
- Encoding
  - L = route_len, D = NBD-L data bits per chunk.
  - Chunk k places route[L-1:0] in out_d[NBD-1 -: L] and payload[k*D +: D] in out_d[D-1:0].
  - Payload bits beyond NPAY read as 0. Payload bits above nchunks*D are discarded.
  - Chunks are sent LSB-first, k=0..nchunks-1.
- FSM IDLE
  - in_a = !out_v || out_a (full throughput for 1-chunk leaves).
  - Accept with nchunks>=1: load chunk 0 into the out register (out_v=1) on the same edge.
  - If nchunks>1: latch payload/entry, set k=1, go to BUSY.
  - Accept with nchunks=0: consume, no output, err_drop=1 next cycle. If out_v was high and out_a=0, the pending output is untouched.
- FSM BUSY
  - in_a=0.
  - On each out transfer, load chunk k into the out register and increment k.
  - When chunk nchunks-1 is loaded, return to IDLE.
  - If out_a=0, hold state and outputs.
- Latency
  - 1 cycle from input accept to out_v.
  - Back-to-back 1-chunk words: one output per cycle.
  - n-chunk word: occupies n output transfers and blocks input for n-1 of them.
- Boundaries
  - L=0: full 21-bit payload slice.
  - L=8: D=13. With nchunks=3 this covers 39 bits; the top 12 bits are zero.
  - Reset asserted mid-packet aborts the packet: no remaining chunks are sent, out_v drops immediately.
  - err_drop never asserts for valid leaves.

Test Plan:
- Post-reset, leaf 0, payload 0x1ABCDE, out_a=1 -> one word out_d=0x1ABCDE after 1 cycle; in_a stays high.
- Config leaf 3 route=0b101 len=3 nchunks=1; send payload 0x0012345 -> out_d=0x152345.
- Config leaf 7 route=0b11 len=2 nchunks=2; send payload 0x7FFFFFF -> out_d=0x1FFFFF, then 0x1800FF; in_a=0 between them.
- Same 2-chunk word with out_a held 0 for 5 cycles after first out_v:
  - out_d held at 0x1FFFFF and in_a=0 throughout.
  - Second chunk follows the first transfer.
- Config leaf 9 nchunks=0; send any payload -> accepted, no out_v, err_drop high exactly 1 cycle.
- Streams and corner events:
  - 100 random leaves/payloads under random out_a -> output matches the scoreboard model.
  - cfg write to leaf 3 on its accept edge -> old entry used.
  - reset asserted mid-chunk -> out_v=0 immediately, no residual chunk after release.
